// File: rtl/multicycle_ctrl.sv
// Multi-cycle FETCH/DECODE/EXE/MEM/WB sequencer for the MIPS-subset datapath, with a retired-instruction counter.
// Optional build macro ILLEGAL_TRAP_EN: unknown instructions park the sequencer in ILL until reset (otherwise they retire as nop).
module multicycle_ctrl #(
    parameter int CNT_W    = 32,
    parameter int MEM_WAIT = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      instr,
    input  logic             zero,
    output logic             ir_we,
    output logic             pc_we,
    output logic             cpc,
    output logic [1:0]       cpcop,
    output logic             isbeq,
    output logic [1:0]       regdst,
    output logic [3:0]       memtoreg,
    output logic             regwrite,
    output logic             memwrite,
    output logic             alusrc,
    output logic [1:0]       extop,
    output logic [1:0]       aluctrl,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXE    = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_ILL    = 3'd5
    } state_t;

    typedef enum logic [3:0] {
        K_NOP, K_ADDU, K_SUBU, K_ORI, K_LUI, K_LW, K_SW,
        K_BEQ, K_J, K_JAL, K_JR, K_BAD
    } kind_t;

`ifdef ILLEGAL_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    state_t     cur;
    kind_t      kind;
    logic [1:0] wait_cnt;
    logic       mem_done;
    logic       last;

    always_comb begin
        // NOTE: every signal assigned in a combinational block gets a default first, so no path can infer a latch.
        kind = K_BAD;
        if (instr == 32'd0) begin
            kind = K_NOP;
        end else begin
            case (instr[31:26])
                6'h00: begin
                    case (instr[5:0])
                        6'h21:   kind = K_ADDU;
                        6'h23:   kind = K_SUBU;
                        6'h08:   kind = K_JR;
                        default: kind = K_BAD;
                    endcase
                end
                6'h0d:   kind = K_ORI;
                6'h0f:   kind = K_LUI;
                6'h23:   kind = K_LW;
                6'h2b:   kind = K_SW;
                6'h04:   kind = K_BEQ;
                6'h02:   kind = K_J;
                6'h03:   kind = K_JAL;
                default: kind = K_BAD;
            endcase
        end
    end

    // Datapath fields depend only on the held instruction, so they stay flat for the whole instruction.
    always_comb begin
        alusrc   = 1'b0;
        extop    = 2'b00;
        aluctrl  = 2'b00;
        regdst   = 2'b00;
        memtoreg = 4'b0001;
        cpcop    = 2'b00;
        isbeq    = 1'b0;
        case (kind)
            K_ADDU: regdst = 2'b01;
            K_SUBU: begin regdst = 2'b01; aluctrl = 2'b01; end
            K_ORI:  begin alusrc = 1'b1; aluctrl = 2'b10; end
            K_LUI:  begin extop = 2'b10; memtoreg = 4'b0100; end
            K_LW:   begin alusrc = 1'b1; extop = 2'b01; memtoreg = 4'b0010; end
            K_SW:   begin alusrc = 1'b1; extop = 2'b01; end
            K_BEQ:  begin isbeq = 1'b1; aluctrl = 2'b01; cpcop = 2'b01; end
            K_J:    cpcop = 2'b10;
            K_JAL:  begin regdst = 2'b10; memtoreg = 4'b1000; cpcop = 2'b10; end
            K_JR:   cpcop = 2'b11;
            default: ;
        endcase
    end

    assign mem_done = (wait_cnt == 2'(MEM_WAIT));

    // last marks the final state of the instruction: the one cycle PC is written.
    always_comb begin
        last = 1'b0;
        case (cur)
            S_DECODE: last = (kind == K_J) || (kind == K_NOP) || ((kind == K_BAD) && !TRAP_EN);
            S_EXE:    last = (kind == K_BEQ) || (kind == K_JR);
            S_MEM:    last = (kind == K_SW) && mem_done;
            S_WB:     last = 1'b1;
            default:  last = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            cur      <= S_FETCH;
            wait_cnt <= 2'd0;
            retired  <= '0;
        end else begin
            if (last) retired <= retired + CNT_W'(1);
            case (cur)
                S_FETCH: cur <= S_DECODE;
                S_DECODE: begin
                    case (kind)
                        K_ADDU, K_SUBU, K_ORI, K_LW, K_SW, K_BEQ, K_JR: cur <= S_EXE;
                        K_LUI, K_JAL: cur <= S_WB;
                        K_BAD:        cur <= TRAP_EN ? S_ILL : S_FETCH;
                        default:      cur <= S_FETCH;
                    endcase
                end
                S_EXE: begin
                    if (kind == K_LW || kind == K_SW) begin
                        cur      <= S_MEM;
                        wait_cnt <= 2'd0;
                    end else if (kind == K_ADDU || kind == K_SUBU || kind == K_ORI) begin
                        cur <= S_WB;
                    end else begin
                        cur <= S_FETCH;
                    end
                end
                S_MEM: begin
                    if (mem_done) cur <= (kind == K_LW) ? S_WB : S_FETCH;
                    else          wait_cnt <= wait_cnt + 2'd1;
                end
                S_WB:    cur <= S_FETCH;
                S_ILL:   cur <= S_ILL;
                default: cur <= S_FETCH;
            endcase
        end
    end

    // Enables are gated by reset so an aborted instruction can never leave a partial write.
    assign state    = cur;
    assign ir_we    = !reset && (cur == S_FETCH);
    assign pc_we    = !reset && last;
    assign regwrite = !reset && (cur == S_WB);
    assign memwrite = !reset && (cur == S_MEM) && (kind == K_SW) && mem_done;
    assign cpc      = !reset && (((cur == S_DECODE) && (kind == K_J))
                              || ((cur == S_EXE) && (kind == K_BEQ) && zero)
                              || ((cur == S_EXE) && (kind == K_JR))
                              || ((cur == S_WB) && (kind == K_JAL)));

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: per-instruction state-sequence model plus literal pins, MEM_WAIT=2.
// A second CNT_W=2 instance exercises counter wrap.
module tb_multicycle_ctrl;

    localparam int MW = 2;

    logic        clk = 1'b0;
    logic        reset, zero;
    logic [31:0] instr;
    logic        ir_we, pc_we, cpc, isbeq, regwrite, memwrite, alusrc;
    logic [1:0]  cpcop, regdst, extop, aluctrl;
    logic [3:0]  memtoreg;
    logic [2:0]  state;
    logic [31:0] retired;

    logic        s_ir_we, s_pc_we, s_cpc, s_isbeq, s_regwrite, s_memwrite, s_alusrc;
    logic [1:0]  s_cpcop, s_regdst, s_extop, s_aluctrl;
    logic [3:0]  s_memtoreg;
    logic [2:0]  s_state;
    logic [1:0]  s_retired;

    multicycle_ctrl #(.CNT_W(32), .MEM_WAIT(MW)) dut (
        .clk(clk), .reset(reset), .instr(instr), .zero(zero),
        .ir_we(ir_we), .pc_we(pc_we), .cpc(cpc), .cpcop(cpcop), .isbeq(isbeq),
        .regdst(regdst), .memtoreg(memtoreg), .regwrite(regwrite), .memwrite(memwrite),
        .alusrc(alusrc), .extop(extop), .aluctrl(aluctrl), .state(state), .retired(retired)
    );

    multicycle_ctrl #(.CNT_W(2), .MEM_WAIT(MW)) dut_small (
        .clk(clk), .reset(reset), .instr(instr), .zero(zero),
        .ir_we(s_ir_we), .pc_we(s_pc_we), .cpc(s_cpc), .cpcop(s_cpcop), .isbeq(s_isbeq),
        .regdst(s_regdst), .memtoreg(s_memtoreg), .regwrite(s_regwrite), .memwrite(s_memwrite),
        .alusrc(s_alusrc), .extop(s_extop), .aluctrl(s_aluctrl), .state(s_state), .retired(s_retired)
    );

    always #5 clk = ~clk;

    typedef enum {M_NOP, M_ADDU, M_SUBU, M_ORI, M_LUI, M_LW, M_SW,
                  M_BEQ, M_J, M_JAL, M_JR, M_BAD} mkind_t;

    int          n_cmp = 0;
    int          n_bad = 0;
    bit          chk_en = 1'b0;
    mkind_t      m_kind = M_NOP;
    int          m_state = 0;
    int          m_idx = 0;
    bit          m_last = 1'b0;
    bit          m_zero = 1'b0;
    logic [31:0] m_retired = 32'd0;
    int          obs_len = 0;
    int          mw_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic mkind_t classify(input logic [31:0] i);
        if (i == 32'd0) return M_NOP;
        case (i[31:26])
            6'h00:   return (i[5:0] == 6'h21) ? M_ADDU :
                            (i[5:0] == 6'h23) ? M_SUBU :
                            (i[5:0] == 6'h08) ? M_JR : M_BAD;
            6'h0d:   return M_ORI;
            6'h0f:   return M_LUI;
            6'h23:   return M_LW;
            6'h2b:   return M_SW;
            6'h04:   return M_BEQ;
            6'h02:   return M_J;
            6'h03:   return M_JAL;
            default: return M_BAD;
        endcase
    endfunction

    // Compare process: DUT against model, sampled mid-cycle.
    always @(negedge clk) begin
        if (chk_en) begin
            check("state", 32'(state), 32'(m_state));
            check("ir_we", 32'(ir_we), 32'(m_state == 0));
            check("pc_we", 32'(pc_we), 32'(m_last));
            check("regwrite", 32'(regwrite), 32'(m_state == 4));
            check("memwrite", 32'(memwrite), 32'(m_last && m_kind == M_SW));
            check("cpc", 32'(cpc), 32'(m_last && (m_kind == M_J || m_kind == M_JAL || m_kind == M_JR
                                               || (m_kind == M_BEQ && m_zero))));
            check("retired", retired, m_retired);
            check("retired_wrap", 32'(s_retired), 32'(m_retired[1:0]));
            if (pc_we) obs_len = m_idx + 1;
            if (memwrite) mw_cnt++;
            if (m_state != 0 && m_state != 5) begin
                check("isbeq", 32'(isbeq), 32'(m_kind == M_BEQ));
                case (m_kind)
                    M_ADDU, M_SUBU: begin
                        check("regdst", 32'(regdst), 32'h1);
                        check("aluctrl", 32'(aluctrl), (m_kind == M_SUBU) ? 32'h1 : 32'h0);
                        check("memtoreg", 32'(memtoreg), 32'h1);
                    end
                    M_ORI: begin
                        check("alusrc", 32'(alusrc), 32'h1);
                        check("extop", 32'(extop), 32'h0);
                        check("aluctrl", 32'(aluctrl), 32'h2);
                        check("regdst", 32'(regdst), 32'h0);
                        check("memtoreg", 32'(memtoreg), 32'h1);
                    end
                    M_LUI: begin
                        check("extop", 32'(extop), 32'h2);
                        check("memtoreg", 32'(memtoreg), 32'h4);
                        check("regdst", 32'(regdst), 32'h0);
                    end
                    M_LW, M_SW: begin
                        check("alusrc", 32'(alusrc), 32'h1);
                        check("extop", 32'(extop), 32'h1);
                        check("aluctrl", 32'(aluctrl), 32'h0);
                        if (m_kind == M_LW) check("memtoreg", 32'(memtoreg), 32'h2);
                    end
                    M_BEQ: begin
                        check("aluctrl", 32'(aluctrl), 32'h1);
                        check("cpcop", 32'(cpcop), 32'h1);
                    end
                    M_J:   check("cpcop", 32'(cpcop), 32'h2);
                    M_JAL: begin
                        check("regdst", 32'(regdst), 32'h2);
                        check("memtoreg", 32'(memtoreg), 32'h8);
                        check("cpcop", 32'(cpcop), 32'h2);
                    end
                    M_JR:  check("cpcop", 32'(cpcop), 32'h3);
                    default: ;
                endcase
            end
        end
    end

    // Runs one instruction from its FETCH cycle (called just after a rising edge).
    task automatic run(input logic [31:0] ins, input logic z);
        int q[$];
        mkind_t k;
        k = classify(ins);
        q.push_back(0);
        q.push_back(1);
        case (k)
            M_ADDU, M_SUBU, M_ORI: begin q.push_back(2); q.push_back(4); end
            M_LUI, M_JAL:          q.push_back(4);
            M_LW, M_SW: begin
                q.push_back(2);
                repeat (MW + 1) q.push_back(3);
                if (k == M_LW) q.push_back(4);
            end
            M_BEQ, M_JR:           q.push_back(2);
`ifdef ILLEGAL_TRAP_EN
            M_BAD:                 repeat (4) q.push_back(5);
`endif
            default: ;
        endcase
        instr   = ins;
        zero    = z;
        m_kind  = k;
        m_zero  = z;
        obs_len = 0;
        mw_cnt  = 0;
        for (int i = 0; i < q.size(); i++) begin
            m_idx   = i;
            m_state = q[i];
            m_last  = (i == q.size() - 1) && (q[i] != 5);
            @(posedge clk);
            #1;
            if (m_last) m_retired = m_retired + 32'd1;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        instr = 32'd0;
        zero  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_state", 32'(state), 32'd0);
        check("rst_retired", retired, 32'd0);
        check("rst_ir_we", 32'(ir_we), 32'd0);
        check("rst_pc_we", 32'(pc_we), 32'd0);

        // Abort an addu in EXE with an asynchronous reset.
        reset = 1'b0;
        instr = 32'h00221821;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("pre_abort_exe", 32'(state), 32'd2);
        #3;
        reset = 1'b1;
        #1;
        check("abort_state", 32'(state), 32'd0);
        check("abort_retired", retired, 32'd0);
        check("abort_regwrite", 32'(regwrite), 32'd0);
        repeat (2) begin
            @(posedge clk); #1;
            check("abort_regwrite_hold", 32'(regwrite), 32'd0);
        end
        reset  = 1'b0;
        chk_en = 1'b1;

        run(32'h00221821, 1'b0);           // addu $3,$1,$2
        check("addu_len", 32'(obs_len), 32'd4);
        check("addu_retired", retired, 32'd1);
        run(32'h00221823, 1'b0);           // subu
        run(32'h34010005, 1'b0);           // ori
        run(32'h3C011234, 1'b0);           // lui
        check("lui_len", 32'(obs_len), 32'd3);
        run(32'h8C020004, 1'b0);           // lw
        check("lw_len", 32'(obs_len), 32'd7);
        run(32'hAC020004, 1'b0);           // sw
        check("sw_len", 32'(obs_len), 32'd6);
        check("sw_memwrite_pulses", 32'(mw_cnt), 32'd1);
        run(32'h10000002, 1'b1);           // beq taken
        check("beq1_len", 32'(obs_len), 32'd3);
        run(32'h10000002, 1'b0);           // beq not taken
        check("beq0_len", 32'(obs_len), 32'd3);
        run(32'h08000010, 1'b0);           // j
        check("j_len", 32'(obs_len), 32'd2);
        run(32'h0C000010, 1'b0);           // jal
        check("jal_len", 32'(obs_len), 32'd3);
        run(32'h03E00008, 1'b0);           // jr $31
        check("jr_len", 32'(obs_len), 32'd3);
        run(32'h00000000, 1'b0);           // nop
        check("nop_len", 32'(obs_len), 32'd2);
        check("retired_12", retired, 32'd12);
        run(32'hFC000000, 1'b0);           // unknown opcode
`ifdef ILLEGAL_TRAP_EN
        check("ill_state", 32'(state), 32'd5);
        check("ill_retired", retired, 32'd12);
`else
        check("bad_len", 32'(obs_len), 32'd2);
        check("bad_retired", retired, 32'd13);
`endif
        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
